// File: rtl/ball_physics_engine.sv
// Multi-ball fixed-point physics engine. A tick divider starts a sweep that updates
// one ball per cycle under shared tilt acceleration, with saturation and damped bounce.
module ball_physics_engine #(
    parameter int N_BALLS       = 4,
    parameter int SCREEN_WIDTH  = 400,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BALL_RADIUS   = 20,
    parameter int TICK_DIV      = 16,
    parameter int FRAC_BITS     = 4,
    parameter int VEL_W         = 12,
    parameter int ACCEL_W       = 8,
    parameter int BOUNCE_SHIFT  = 1,
    parameter int MAX_VEL       = 512
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        i_reset_position,
    input  logic [N_BALLS-1:0]          i_reset_mask,
    input  logic signed [ACCEL_W-1:0]   i_accel_x,
    input  logic signed [ACCEL_W-1:0]   i_accel_y,
    input  logic                        i_pause,
    output logic [N_BALLS*9-1:0]        o_ball_x,
    output logic [N_BALLS*10-1:0]       o_ball_y,
    output logic [N_BALLS-1:0]          o_wall_hit,
    output logic                        o_update_done,
    output logic                        o_busy
);
    localparam int SCREEN_MAX = (SCREEN_WIDTH > SCREEN_HEIGHT) ? SCREEN_WIDTH : SCREEN_HEIGHT;
    localparam int POS_W = $clog2(SCREEN_MAX + 1) + 2;
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int IDX_W = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;

    localparam logic signed [POS_W-1:0] R_POS   = POS_W'(BALL_RADIUS);
    localparam logic signed [POS_W-1:0] HI_X    = POS_W'(SCREEN_WIDTH - BALL_RADIUS);
    localparam logic signed [POS_W-1:0] HI_Y    = POS_W'(SCREEN_HEIGHT - BALL_RADIUS);
    localparam logic signed [POS_W-1:0] START_Y = POS_W'(SCREEN_HEIGHT / 2);
    localparam logic signed [VEL_W:0]   VMAX    = (VEL_W+1)'(MAX_VEL);
    localparam logic signed [VEL_W:0]   VMIN    = (VEL_W+1)'(-MAX_VEL);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    typedef struct packed {
        logic signed [POS_W-1:0] p;
        logic signed [VEL_W-1:0] v;
        logic                    hit;
    } axis_t;

    function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [VEL_W:0] v);
        if (v > VMAX) return VMAX[VEL_W-1:0];
        if (v < VMIN) return VMIN[VEL_W-1:0];
        return v[VEL_W-1:0];
    endfunction

    function automatic logic signed [POS_W-1:0] start_x(input int k);
        return POS_W'(SCREEN_WIDTH * (2 * k + 1) / (2 * N_BALLS));
    endfunction

    // One axis of one ball: accelerate, saturate, move, then clamp and bounce at the walls.
    function automatic axis_t axis_step(input logic signed [POS_W-1:0]   p,
                                        input logic signed [VEL_W-1:0]   v,
                                        input logic signed [ACCEL_W-1:0] a,
                                        input logic signed [POS_W-1:0]   hi);
        axis_t r;
        logic signed [VEL_W-1:0] vn;
        logic signed [POS_W-1:0] pn;
        vn = sat_vel({v[VEL_W-1], v} + {{(VEL_W+1-ACCEL_W){a[ACCEL_W-1]}}, a});
        pn = p + POS_W'(vn >>> FRAC_BITS);
        r.p   = pn;
        r.v   = vn;
        r.hit = 1'b0;
        if (pn < R_POS) begin
            r.p   = R_POS;
            r.v   = -(vn >>> BOUNCE_SHIFT);
            r.hit = 1'b1;
        end else if (pn > hi) begin
            r.p   = hi;
            r.v   = -(vn >>> BOUNCE_SHIFT);
            r.hit = 1'b1;
        end
        return r;
    endfunction

    state_t                    state, state_next;
    logic [CNT_W-1:0]          tick_cnt;
    logic [IDX_W-1:0]          idx;
    logic signed [ACCEL_W-1:0] accel_x_l, accel_y_l;
    logic signed [POS_W-1:0]   pos_x [N_BALLS];
    logic signed [POS_W-1:0]   pos_y [N_BALLS];
    logic signed [VEL_W-1:0]   vel_x [N_BALLS];
    logic signed [VEL_W-1:0]   vel_y [N_BALLS];
    logic [N_BALLS-1:0]        wall_hit;
    logic                      tick, start_sweep;
    axis_t                     upd_x, upd_y;

    assign tick        = (tick_cnt == CNT_W'(TICK_DIV - 1)) && !i_pause;
    assign start_sweep = (state == IDLE) && tick;

    always_ff @(posedge clk or posedge arst) begin
        if (arst)                  state <= IDLE;
        else if (i_reset_position) state <= IDLE;
        else                       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = SWEEP;
            SWEEP:   if (idx == IDX_W'(N_BALLS - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy        = (state == SWEEP);
        o_update_done = (state == DONE);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tick_cnt <= '0;
            idx      <= '0;
            wall_hit <= '0;
        end else if (i_reset_position) begin
            tick_cnt <= '0;
            idx      <= '0;
            wall_hit <= '0;
        end else begin
            if (!i_pause)
                tick_cnt <= (tick_cnt == CNT_W'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
            if (start_sweep) begin
                idx      <= '0;
                wall_hit <= '0;
            end else if (state == SWEEP) begin
                idx <= idx + 1'b1;
                if (!i_reset_mask[idx])
                    wall_hit[idx] <= wall_hit[idx] | upd_x.hit | upd_y.hit;
            end
        end
    end

    // Accelerations are frozen for the whole sweep so every ball sees the same tilt.
    always_ff @(posedge clk) begin
        if (start_sweep) begin
            accel_x_l <= i_accel_x;
            accel_y_l <= i_accel_y;
        end
    end

    assign upd_x = axis_step(pos_x[idx], vel_x[idx], accel_x_l, HI_X);
    assign upd_y = axis_step(pos_y[idx], vel_y[idx], accel_y_l, HI_Y);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int k = 0; k < N_BALLS; k++) begin
                pos_x[k] <= start_x(k);
                pos_y[k] <= START_Y;
                vel_x[k] <= '0;
                vel_y[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_BALLS; k++) begin
                if (i_reset_position || i_reset_mask[k]) begin
                    pos_x[k] <= start_x(k);
                    pos_y[k] <= START_Y;
                    vel_x[k] <= '0;
                    vel_y[k] <= '0;
                end else if (state == SWEEP && idx == IDX_W'(k)) begin
                    pos_x[k] <= upd_x.p;
                    pos_y[k] <= upd_y.p;
                    vel_x[k] <= upd_x.v;
                    vel_y[k] <= upd_y.v;
                end
            end
        end
    end

    for (genvar k = 0; k < N_BALLS; k++) begin : g_out
        logic unused_hi;
        assign o_ball_x[9*k +: 9]   = pos_x[k][8:0];
        assign o_ball_y[10*k +: 10] = pos_y[k][9:0];
        assign unused_hi = ^{pos_x[k][POS_W-1:9], pos_y[k][POS_W-1:10]};
    end

    assign o_wall_hit = wall_hit;

endmodule
